// File: rtl/fir_ntap_mac_pipe.sv
// N-tap signed FIR with programmable coefficients: delay line, product register,
// then adder tree into the output register, with valid/ready handshaking and full stall.
module fir_ntap_mac_pipe #(
   parameter  int W   = 16,
   parameter  int N   = 4,
   parameter  int CW  = 8,
   localparam int LGN = $clog2(N),
   localparam int OW  = W + CW + LGN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [W-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] out_data,
   output logic                 out_warm,
   input  logic                 coef_we,
   input  logic [LGN-1:0]       coef_addr,
   input  logic signed [CW-1:0] coef_data,
   input  logic                 avg_en,
   input  logic                 flush
);
   localparam int PW   = W + CW;
   localparam int CNTW = LGN + 1;

   logic signed [W-1:0]  tap_q  [N];
   logic signed [W-1:0]  tap_d  [N];
   logic signed [CW-1:0] coef_q [N];
   logic signed [CW-1:0] coef_d [N];
   logic signed [PW-1:0] p_q    [N];
   logic signed [PW-1:0] p_d    [N];
   logic signed [PW-1:0] prod   [N];

   logic                 v0_q, v0_d;
   logic                 w0_q, w0_d;
   logic                 v1_q, v1_d;
   logic                 w1_q, w1_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_warm_q, out_warm_d;
   logic signed [OW-1:0] out_data_q, out_data_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;

   logic                 stall;
   logic                 accept;
   logic signed [OW-1:0] sum;
   logic signed [OW-1:0] sum_rnd;
   logic signed [OW-1:0] avg;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = reset | (~flush & ~stall);
   assign accept   = in_valid & in_ready;

   for (genvar gi = 0; gi < N; gi++) begin : g_mul
      assign prod[gi] = PW'(coef_q[gi]) * PW'(tap_q[gi]);
   end

   // Delay line shifts per accepted sample; product stage advances per non-stalled edge.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         tap_d[k]  = tap_q[k];
         p_d[k]    = p_q[k];
         coef_d[k] = coef_q[k];
         if (flush) begin
            tap_d[k] = '0;
            p_d[k]   = '0;
         end else if (!stall) begin
            p_d[k] = prod[k];
         end
         if (coef_we && (coef_addr == LGN'(k))) begin
            coef_d[k] = coef_data;
         end
      end
      if (!flush && accept) begin
         tap_d[0] = in_data;
         for (int k = 1; k < N; k++) begin
            tap_d[k] = tap_q[k-1];
         end
      end
   end

   // Sign-extended sum cannot overflow OW; the rounding offset leaves one bit of headroom.
   always_comb begin
      sum = '0;
      for (int k = 0; k < N; k++) begin
         sum = sum + OW'(p_q[k]);
      end
      sum_rnd = sum + OW'(N / 2);
      avg     = sum_rnd >>> LGN;
   end

   always_comb begin
      cnt_d       = cnt_q;
      v0_d        = v0_q;
      w0_d        = w0_q;
      v1_d        = v1_q;
      w1_d        = w1_q;
      out_valid_d = out_valid_q;
      out_warm_d  = out_warm_q;
      out_data_d  = out_data_q;
      if (flush) begin
         cnt_d       = '0;
         v0_d        = 1'b0;
         w0_d        = 1'b0;
         v1_d        = 1'b0;
         w1_d        = 1'b0;
         out_valid_d = 1'b0;
         out_warm_d  = 1'b0;
      end else if (!stall) begin
         if (accept && (cnt_q != CNTW'(N))) begin
            cnt_d = cnt_q + CNTW'(1);
         end
         v0_d        = accept;
         w0_d        = accept && (cnt_q >= CNTW'(N - 1));
         v1_d        = v0_q;
         w1_d        = w0_q;
         out_valid_d = v1_q;
         out_warm_d  = w1_q;
         out_data_d  = avg_en ? avg : sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            tap_q[k]  <= '0;
            p_q[k]    <= '0;
            coef_q[k] <= CW'(1);
         end
         cnt_q       <= '0;
         v0_q        <= 1'b0;
         w0_q        <= 1'b0;
         v1_q        <= 1'b0;
         w1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_warm_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            tap_q[k]  <= tap_d[k];
            p_q[k]    <= p_d[k];
            coef_q[k] <= coef_d[k];
         end
         cnt_q       <= cnt_d;
         v0_q        <= v0_d;
         w0_q        <= w0_d;
         v1_q        <= v1_d;
         w1_q        <= w1_d;
         out_valid_q <= out_valid_d;
         out_warm_q  <= out_warm_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_warm  = out_warm_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_ntap_mac_pipe.sv
// Bench for fir_ntap_mac_pipe: vector table feeds a scoreboard queue, outputs are
// popped and compared on each transfer; hand sequences cover stall, flush and reset.
module tb_fir_ntap_mac_pipe;
   localparam int W   = 16;
   localparam int N   = 4;
   localparam int CW  = 8;
   localparam int LGN = 2;
   localparam int OW  = W + CW + LGN;
   localparam int NV  = 37;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W-1:0]  in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_data;
   logic                 out_warm;
   logic                 coef_we;
   logic [LGN-1:0]       coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 avg_en;
   logic                 flush;

   fir_ntap_mac_pipe #(.W(W), .N(N), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_warm  (out_warm),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .avg_en    (avg_en),
      .flush     (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [W-1:0]  din;
      logic signed [OW-1:0] dout;
      logic                 warm;
   } vec_t;

   typedef struct {
      logic signed [OW-1:0] dout;
      logic                 warm;
      int                   acc_cyc;
      bit                   lat;
      int                   idx;
   } exp_t;

   vec_t tv [NV];
   exp_t sb [$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tvs(input int i, input int d, input int o, input bit w);
      tv[i].din  = W'(d);
      tv[i].dout = OW'(o);
      tv[i].warm = w;
   endtask

   // Output monitor: one line per transfer.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d required no output", out_data);
         end else begin
            mon_e = sb.pop_front();
            $display("out[%0d] data=%0d warm=%0d", mon_e.idx, out_data, out_warm);
            chk($sformatf("out_data[%0d]", mon_e.idx), out_data, mon_e.dout);
            chk($sformatf("out_warm[%0d]", mon_e.idx), out_warm, mon_e.warm);
            if (mon_e.lat) chk($sformatf("latency[%0d]", mon_e.idx), cyc - mon_e.acc_cyc, 2);
         end
      end
   end

   task automatic send(input logic signed [W-1:0] d, input bit push, input int idx, input bit lat);
      int   t;
      exp_t e;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", t);
            return;
         end
      end
      if (push) begin
         e.dout    = tv[idx].dout;
         e.warm    = tv[idx].warm;
         e.acc_cyc = cyc + 1;
         e.lat     = lat;
         e.idx     = idx;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_group(input int lo, input int hi, input bit lat);
      for (int i = lo; i <= hi; i++) send(tv[i].din, 1'b1, i, lat);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wr_coef(input int a, input int d);
      coef_we   = 1'b1;
      coef_addr = LGN'(a);
      coef_data = CW'(d);
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
      wr_coef(0, c0);
      wr_coef(1, c1);
      wr_coef(2, c2);
      wr_coef(3, c3);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_out_valid", out_valid, 0);
   endtask

   task automatic backpressure();
      int t;
      logic signed [OW-1:0] held;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!out_valid && t < 50);
      chk("bp_out_valid_seen", out_valid, 1);
      out_ready = 1'b0;
      held = out_data;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp_in_ready[%0d]", c), in_ready, 0);
         chk($sformatf("bp_out_valid[%0d]", c), out_valid, 1);
         chk($sformatf("bp_out_data_hold[%0d]", c), out_data, held);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish required finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      avg_en    = 1'b0;
      flush     = 1'b0;

      // defaults
      tvs(0, 1, 1, 0);  tvs(1, 2, 3, 0);  tvs(2, 3, 6, 0);  tvs(3, 4, 10, 1);  tvs(4, 5, 14, 1);
      // impulse, coefs 1,2,3,4
      tvs(5, 1, 1, 0);  tvs(6, 0, 2, 0);  tvs(7, 0, 3, 0);  tvs(8, 0, 4, 1);   tvs(9, 0, 0, 1);
      // coefs -128, samples -32768
      tvs(10, -32768, 4194304, 0);  tvs(11, -32768, 8388608, 0);
      tvs(12, -32768, 12582912, 0); tvs(13, -32768, 16777216, 1);
      // coefs +127, samples +32767
      tvs(14, 32767, 4161409, 0);   tvs(15, 32767, 8322818, 0);
      tvs(16, 32767, 12484227, 0);  tvs(17, 32767, 16645636, 1);
      // backpressure stream
      tvs(18, 10, 10, 0);  tvs(19, 20, 30, 0);  tvs(20, 30, 60, 0);
      tvs(21, 40, 100, 1); tvs(22, 50, 140, 1); tvs(23, 60, 180, 1);
      // averaging, then after flush
      tvs(24, 3, 1, 0);  tvs(25, 3, 2, 0);  tvs(26, 3, 2, 0);  tvs(27, 2, 3, 1);
      tvs(28, -5, -1, 0);
      // after mid-stream flush with coef3 written during the flush
      tvs(29, 7, 7, 0);  tvs(30, 0, 14, 0); tvs(31, 0, 21, 0); tvs(32, 0, 28, 1);
      // after mid-stream reset, coefs back to +1
      tvs(33, 1, 1, 0);  tvs(34, 2, 3, 0);  tvs(35, 3, 6, 0);  tvs(36, 4, 10, 1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_warm", out_warm, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_group(0, 4, 1'b1);
      drain();

      set_coefs(1, 2, 3, 4);
      do_flush();
      run_group(5, 9, 1'b1);
      drain();

      set_coefs(-128, -128, -128, -128);
      do_flush();
      run_group(10, 13, 1'b1);
      drain();

      set_coefs(127, 127, 127, 127);
      do_flush();
      run_group(14, 17, 1'b1);
      drain();

      set_coefs(1, 1, 1, 1);
      do_flush();
      fork
         run_group(18, 23, 1'b0);
         backpressure();
      join
      drain();

      avg_en = 1'b1;
      do_flush();
      run_group(24, 27, 1'b1);
      drain();
      do_flush();
      run_group(28, 28, 1'b1);
      drain();
      avg_en = 1'b0;

      // two samples in flight when flush hits, coef write in the same cycle
      set_coefs(1, 2, 3, 0);
      do_flush();
      send(16'sd9, 1'b0, -1, 1'b0);
      send(16'sd9, 1'b0, -1, 1'b0);
      in_valid  = 1'b0;
      coef_we   = 1'b1;
      coef_addr = 2'd3;
      coef_data = 8'sd4;
      do_flush();
      coef_we = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_drop_second", out_valid, 0);
      run_group(29, 32, 1'b1);
      drain();

      // reset with two samples in flight
      set_coefs(5, 6, 7, 8);
      send(16'sd9, 1'b0, -1, 1'b0);
      send(16'sd9, 1'b0, -1, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      chk("midreset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("midreset_drop_second", out_valid, 0);
      run_group(33, 36, 1'b1);
      drain();

      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
